video_shifter: RTL and testbench

VIDEO_SHIFTER -- requirements
Module: video_shifter

---
 rtl/video_shifter.sv | 147 ++++++++++++++
 tb/tb_video_shifter.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/video_shifter.sv
// Raster timing generator and 1-bpp pixel shifter: 320x262 raster with a 256x224 active window,
// fetching one VRAM byte per 8 pixels and colouring set bits by a line-dependent overlay.
module video_shifter (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        PE,
    output logic [12:0] VRAM_A,
    output logic        VRAM_RE,
    input  logic [7:0]  VRAM_D,
    output logic [2:0]  PIX,
    output logic        DT,
    output logic        HS,
    output logic        VS,
    output logic        MIDINT,
    output logic        VBLINT
);

    logic [8:0]  h_r;
    logic [8:0]  v_r;
    logic [7:0]  stage_r;
    logic [7:0]  shift_r;
    logic        rd_pend_r;
    logic [12:0] vram_a_r;
    logic        vram_re_r;
    logic [2:0]  pix_r;
    logic        dt_r;
    logic        hs_r;
    logic        vs_r;
    logic        midint_r;
    logic        vblint_r;

    logic        h_last_s;
    logic        v_last_s;
    logic        fetch_s;
    logic        load_s;
    logic        dt_s;
    logic        hs_s;
    logic        vs_s;
    logic        bit_s;
    logic [2:0]  pix_s;

    function automatic logic [2:0] overlay(input logic [8:0] v);
        logic [2:0] c;
        if (v >= 9'd16 && v <= 9'd47) begin
            c = 3'b100;
        end else if (v >= 9'd176 && v <= 9'd215) begin
            c = 3'b010;
        end else begin
            c = 3'b111;
        end
        return c;
    endfunction

    // Decode of the current raster position; the load bit is taken straight from staging
    // because the shift register only receives the byte on this same edge.
    always_comb begin
        h_last_s = (h_r == 9'd319);
        v_last_s = (v_r == 9'd261);
        fetch_s  = (h_r[2:0] == 3'd0) && (h_r < 9'd256) && (v_r < 9'd224);
        load_s   = (h_r[2:0] == 3'd0) && (h_r >= 9'd8) && (h_r <= 9'd263);
        dt_s     = (h_r >= 9'd8) && (h_r <= 9'd263) && (v_r < 9'd224);
        hs_s     = (h_r >= 9'd272) && (h_r <= 9'd303);
        vs_s     = (v_r >= 9'd234) && (v_r <= 9'd236);
        if (load_s) begin
            bit_s = stage_r[0];
        end else begin
            bit_s = shift_r[1];
        end
        if (dt_s && bit_s) begin
            pix_s = overlay(v_r);
        end else begin
            pix_s = 3'b000;
        end
    end

    // Raster counters, advancing once per pixel enable.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            h_r <= 9'd0;
            v_r <= 9'd0;
        end else if (PE) begin
            if (h_last_s) begin
                h_r <= 9'd0;
                v_r <= v_last_s ? 9'd0 : v_r + 9'd1;
            end else begin
                h_r <= h_r + 9'd1;
            end
        end
    end

    // VRAM read strobe and capture; capture runs on raw CLK so a sparse PE never drops data.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            vram_re_r <= 1'b0;
            vram_a_r  <= 13'd0;
            rd_pend_r <= 1'b0;
            stage_r   <= 8'd0;
        end else begin
            vram_re_r <= PE && fetch_s;
            if (PE && fetch_s) begin
                vram_a_r <= {v_r[7:0], h_r[7:3]};
            end
            rd_pend_r <= vram_re_r;
            if (rd_pend_r) begin
                stage_r <= VRAM_D;
            end
        end
    end

    // Pixel shifter and registered video/sync outputs.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            shift_r <= 8'd0;
            pix_r   <= 3'b000;
            dt_r    <= 1'b0;
            hs_r    <= 1'b0;
            vs_r    <= 1'b0;
        end else if (PE) begin
            shift_r <= load_s ? stage_r : {1'b0, shift_r[7:1]};
            pix_r   <= pix_s;
            dt_r    <= dt_s;
            hs_r    <= hs_s;
            vs_r    <= vs_s;
        end
    end

    // Interrupt pulses; a held counter cannot stretch them since PE gates each one.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            midint_r <= 1'b0;
            vblint_r <= 1'b0;
        end else begin
            midint_r <= PE && (h_r == 9'd0) && (v_r == 9'd96);
            vblint_r <= PE && (h_r == 9'd0) && (v_r == 9'd224);
        end
    end

    assign VRAM_A  = vram_a_r;
    assign VRAM_RE = vram_re_r;
    assign PIX     = pix_r;
    assign DT      = dt_r;
    assign HS      = hs_r;
    assign VS      = vs_r;
    assign MIDINT  = midint_r;
    assign VBLINT  = vblint_r;

endmodule

// File: tb/tb_video_shifter.sv
// Self-checking bench for video_shifter: raster-position reference model plus a VRAM image,
// with 1-of-4 PE, mid-line reset, one full continuous-PE frame and a random-PE tail.
module tb_video_shifter;

    logic        CLK = 1'b0;
    logic        RESET = 1'b1;
    logic        PE = 1'b0;
    logic [12:0] VRAM_A;
    logic        VRAM_RE;
    logic [7:0]  VRAM_D = 8'd0;
    logic [2:0]  PIX;
    logic        DT, HS, VS, MIDINT, VBLINT;

    video_shifter dut (
        .CLK(CLK), .RESET(RESET), .PE(PE),
        .VRAM_A(VRAM_A), .VRAM_RE(VRAM_RE), .VRAM_D(VRAM_D),
        .PIX(PIX), .DT(DT), .HS(HS), .VS(VS),
        .MIDINT(MIDINT), .VBLINT(VBLINT)
    );

    always #5 CLK = ~CLK;

    logic [7:0] mem [0:8191];
    int vectors = 0;
    int miscompares = 0;

    // model raster position (before the current edge) and expected outputs
    int mh = 0, mv = 0, ph = 0, pv = 0;
    logic        exp_re = 1'b0, exp_dt = 1'b0, exp_hs = 1'b0, exp_vs = 1'b0;
    logic        exp_mid = 1'b0, exp_vbl = 1'b0;
    logic [12:0] exp_a = 13'd0;
    logic [2:0]  exp_pix = 3'b000;
    logic        re_prev = 1'b0;
    logic [12:0] a_prev = 13'd0;

    function automatic logic [2:0] ovl(input int v);
        if (v >= 16 && v <= 47) return 3'b100;
        if (v >= 176 && v <= 215) return 3'b010;
        return 3'b111;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            if (miscompares <= 30)
                $display("FAIL %s: got %0h expected %0h (pre-edge h=%0d v=%0d, t=%0t)",
                         name, act, exp, ph, pv, $time);
        end
    endtask

    task automatic step(input logic pe_i, input logic rst_i);
        int idx;
        int bp;
        logic dt;
        PE = pe_i;
        RESET = rst_i;
        @(posedge CLK);
        ph = mh;
        pv = mv;
        if (rst_i) begin
            exp_re = 1'b0; exp_a = 13'd0; exp_pix = 3'b000; exp_dt = 1'b0;
            exp_hs = 1'b0; exp_vs = 1'b0; exp_mid = 1'b0; exp_vbl = 1'b0;
            mh = 0; mv = 0;
        end else begin
            exp_re  = pe_i && (mh % 8 == 0) && (mh < 256) && (mv < 224);
            if (exp_re) exp_a = 13'(mv * 32 + mh / 8);
            exp_mid = pe_i && mh == 0 && mv == 96;
            exp_vbl = pe_i && mh == 0 && mv == 224;
            if (pe_i) begin
                dt = (mh >= 8) && (mh <= 263) && (mv < 224);
                exp_dt = dt;
                exp_hs = (mh >= 272) && (mh <= 303);
                exp_vs = (mv >= 234) && (mv <= 236);
                exp_pix = 3'b000;
                if (dt) begin
                    idx = mv * 32 + (mh - 8) / 8;
                    bp  = (mh - 8) % 8;
                    if (mem[idx][bp]) exp_pix = ovl(mv);
                end
                mh = mh + 1;
                if (mh == 320) begin
                    mh = 0;
                    mv = (mv == 261) ? 0 : mv + 1;
                end
            end
        end
        #1;
        chk("VRAM_RE", 32'(VRAM_RE), 32'(exp_re));
        chk("VRAM_A", 32'(VRAM_A), 32'(exp_a));
        chk("PIX", 32'(PIX), 32'(exp_pix));
        chk("DT", 32'(DT), 32'(exp_dt));
        chk("HS", 32'(HS), 32'(exp_hs));
        chk("VS", 32'(VS), 32'(exp_vs));
        chk("MIDINT", 32'(MIDINT), 32'(exp_mid));
        chk("VBLINT", 32'(VBLINT), 32'(exp_vbl));
        // VRAM answers one clock after the strobe; garbage on the bus at every other time
        if (re_prev) VRAM_D = mem[a_prev];
        else VRAM_D = 8'($urandom);
        re_prev = VRAM_RE;
        a_prev = VRAM_A;
    endtask

    initial begin
        int c;
        int reached;
        int mid_cnt, vbl_cnt, re_l0, re_late, hs_l5, vs_lines;
        for (int i = 0; i < 8192; i++) mem[i] = 8'($urandom);
        mem[0]       = 8'h01;
        mem[20 * 32] = 8'hFF;
        mem[180 * 32] = 8'hFF;
        mem[100 * 32] = 8'hFF;

        // reset with PE low and high
        step(1'b0, 1'b1);
        step(1'b1, 1'b1);
        chk("rst_pix", 32'(PIX), 32'd0);
        chk("rst_re", 32'(VRAM_RE), 32'd0);
        chk("rst_a", 32'(VRAM_A), 32'd0);

        // PE 1-of-4 until just after the fetch at h=136 on line 1, then reset mid-line
        reached = 0;
        c = 0;
        while (c < 4000 && reached == 0) begin
            step(c % 4 == 0, 1'b0);
            if (mh == 137 && mv == 1) reached = 1;
            c++;
        end
        chk("reach_reset_point", 32'(reached), 32'd1);
        step(1'($urandom_range(0, 1)), 1'b1);
        chk("midrst_re", 32'(VRAM_RE), 32'd0);
        chk("midrst_a", 32'(VRAM_A), 32'd0);
        chk("midrst_dt", 32'(DT), 32'd0);
        step(1'b1, 1'b1);

        // one full frame at continuous PE, plus the first edge of the next frame
        mid_cnt = 0; vbl_cnt = 0; re_l0 = 0; re_late = 0; hs_l5 = 0; vs_lines = 0;
        for (int i = 0; i < 320 * 262; i++) begin
            step(1'b1, 1'b0);
            if (i == 0) begin
                chk("first_re", 32'(VRAM_RE), 32'd1);
                chk("first_a", 32'(VRAM_A), 32'd0);
            end
            if (MIDINT) mid_cnt++;
            if (VBLINT) vbl_cnt++;
            if (VRAM_RE && pv == 0) re_l0++;
            if (VRAM_RE && pv >= 224) re_late++;
            if (HS && pv == 5) hs_l5++;
            if (VS && ph == 0) vs_lines++;
            if (pv == 0 && ph == 8) chk("x0_pix", 32'(PIX), 32'h7);
            if (pv == 0 && ph >= 9 && ph <= 15) chk("x1_7_pix", 32'(PIX), 32'h0);
            if (pv == 20 && ph >= 8 && ph <= 15) chk("v20_pix", 32'(PIX), 32'h4);
            if (pv == 180 && ph >= 8 && ph <= 15) chk("v180_pix", 32'(PIX), 32'h2);
            if (pv == 100 && ph >= 8 && ph <= 15) chk("v100_pix", 32'(PIX), 32'h7);
        end
        chk("midint_count", 32'(mid_cnt), 32'd1);
        chk("vblint_count", 32'(vbl_cnt), 32'd1);
        chk("re_line0", 32'(re_l0), 32'd32);
        chk("re_vblank", 32'(re_late), 32'd0);
        chk("hs_width", 32'(hs_l5), 32'd32);
        chk("vs_lines", 32'(vs_lines), 32'd3);
        step(1'b1, 1'b0);
        chk("wrap_re", 32'(VRAM_RE), 32'd1);
        chk("wrap_a", 32'(VRAM_A), 32'd0);

        // random PE tail
        for (int i = 0; i < 600; i++) step(1'($urandom_range(0, 1)), 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
